// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
// Shared definitions for the push-button front end.
//   btn_state_t  : debounce FSM state encoding (2 bits)
//   BTN_DB_10MS  : debounce length for 10 ms at 100 MHz
//   BTN_LONG_1S  : long-press length for 1 s at 100 MHz
// -----------------------------------------------------------------------------
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DB_PRESS   = 2'd1,
        HELD       = 2'd2,
        DB_RELEASE = 2'd3
    } btn_state_t;

    localparam int BTN_DB_10MS = 1_000_000;
    localparam int BTN_LONG_1S = 100_000_000;

endpackage

// File: rtl/btn_conditioner_if.sv
// -----------------------------------------------------------------------------
// btn_conditioner_if
// Bundles the pad/tick inputs and the conditioned outputs of one button.
//   btn_raw    : asynchronous pad level
//   tick       : one-cycle sampling enable from the consumer's divider
//   level      : debounced pressed level
//   press      : one-cycle pulse on accepted press
//   press_held : press request held until the consumer's tick
//   long_press : one-cycle pulse once per long hold
// master modport: the conditioner. slave modport: pad/consumer side.
// -----------------------------------------------------------------------------
interface btn_conditioner_if;

    logic btn_raw;
    logic tick;
    logic level;
    logic press;
    logic press_held;
    logic long_press;

    modport master (
        input  btn_raw,
        input  tick,
        output level,
        output press,
        output press_held,
        output long_press
    );

    modport slave (
        output btn_raw,
        output tick,
        input  level,
        input  press,
        input  press_held,
        input  long_press
    );

endinterface

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// One-bit two-flop synchroniser for asynchronous pad inputs (buttons,
// enables, DIP switches).
//   clk       : destination clock
//   rst_n     : synchronous active-low reset, loads RESET_VAL into both flops
//   d         : asynchronous input
//   q         : synchronised output, two cycles behind d
// -----------------------------------------------------------------------------
module sync_2ff #(
    parameter bit RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
// Synchronises and debounces one push-button, emits a one-cycle press pulse,
// holds a press request until the consumer's tick, and flags a long press
// once per hold.
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   btn   : btn_conditioner_if.master (btn_raw, tick in; level, press,
//           press_held, long_press out)
// Parameters:
//   DB_CYCLES   : stable synchronised cycles to accept a level change (>= 2)
//   LONG_CYCLES : accepted-high cycles before long_press (> DB_CYCLES)
//   ACTIVE_HIGH : 1 = pad high means pressed, 0 = pad is inverted
// -----------------------------------------------------------------------------
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int DB_CYCLES   = BTN_DB_10MS,
    parameter int LONG_CYCLES = BTN_LONG_1S,
    parameter bit ACTIVE_HIGH = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    btn_conditioner_if.master btn
);

    localparam int DBW = $clog2(DB_CYCLES + 1);
    localparam int HW  = $clog2(LONG_CYCLES + 1);

    // The cycle in which btn_s first differs from the accepted level is spent
    // in IDLE/HELD and counts toward the debounce, so the debounce state
    // itself only needs DB_CYCLES-1 cycles: db_cnt runs 0 .. DB_CYCLES-2.
    localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 2);
    localparam logic [HW-1:0]  LONG_MAX  = HW'(LONG_CYCLES);
    localparam logic [HW-1:0]  LONG_NEXT = HW'(LONG_CYCLES - 1);

    btn_state_t     state;
    btn_state_t     next_state;
    logic           pad;
    logic           btn_s;
    logic [DBW-1:0] db_cnt;
    logic [HW-1:0]  hold_cnt;
    logic           level;
    logic           press_set;
    logic           press_reg;
    logic           press_held_reg;
    logic           long_press_reg;

    // Polarity is applied before the synchroniser so everything downstream
    // sees 1 = pressed.
    assign pad = ACTIVE_HIGH ? btn.btn_raw : ~btn.btn_raw;

    sync_2ff #(
        .RESET_VAL (1'b0)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pad),
        .q     (btn_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (btn_s) next_state = DB_PRESS;
            end
            DB_PRESS: begin
                if (!btn_s)                 next_state = IDLE;
                else if (db_cnt == DB_LAST) next_state = HELD;
            end
            HELD: begin
                if (!btn_s) next_state = DB_RELEASE;
            end
            DB_RELEASE: begin
                if (btn_s)                  next_state = HELD;
                else if (db_cnt == DB_LAST) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        level     = 1'b0;
        press_set = 1'b0;
        case (state)
            HELD, DB_RELEASE: level = 1'b1;
            default:          level = 1'b0;
        endcase
        // Only the debounced press edge is a new press; a glitch that
        // returns DB_RELEASE to HELD is not.
        press_set = (state == DB_PRESS) && (next_state == HELD);
    end

    // Debounce counter restarts on every state change.
    always_ff @(posedge clk) begin
        if (!rst_n || (next_state != state)) begin
            db_cnt <= '0;
        end else if ((state == DB_PRESS) || (state == DB_RELEASE)) begin
            db_cnt <= db_cnt + DBW'(1);
        end
    end

    // Hold counter saturates at LONG_CYCLES, so the long-press compare can
    // only match once per accepted press.
    always_ff @(posedge clk) begin
        if (!rst_n || press_set || !level) begin
            hold_cnt <= '0;
        end else if (hold_cnt != LONG_MAX) begin
            hold_cnt <= hold_cnt + HW'(1);
        end
    end

    // Registered outputs. press_held: set has priority over the tick clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            press_reg      <= 1'b0;
            press_held_reg <= 1'b0;
            long_press_reg <= 1'b0;
        end else begin
            press_reg      <= press_set;
            press_held_reg <= press_set | (press_held_reg & ~btn.tick);
            long_press_reg <= level && (hold_cnt == LONG_NEXT);
        end
    end

    assign btn.level      = level;
    assign btn.press      = press_reg;
    assign btn.press_held = press_held_reg;
    assign btn.long_press = long_press_reg;

endmodule

// File: tb/tb_btn_conditioner.sv
// -----------------------------------------------------------------------------
// tb_btn_conditioner
// Directed bench for btn_conditioner with DB_CYCLES=4, LONG_CYCLES=20.
// Each scenario counts cycles k from the cycle in which the raw step (or
// reset release) is applied; outputs are sampled 1 time unit after the edge.
// -----------------------------------------------------------------------------
module tb_btn_conditioner;

    localparam int DB   = 4;
    localparam int LONG = 20;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    btn_conditioner_if bus ();

    btn_conditioner #(
        .DB_CYCLES   (DB),
        .LONG_CYCLES (LONG),
        .ACTIVE_HIGH (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input int k, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s k=%0d: observed %b expected %b", tag, k, obs, exp);
        end
    endtask

    task automatic chk_all(input string scen, input int k,
                           input logic l, input logic p, input logic ph, input logic lp);
        chk({scen, ".level"},      k, bus.level,      l);
        chk({scen, ".press"},      k, bus.press,      p);
        chk({scen, ".press_held"}, k, bus.press_held, ph);
        chk({scen, ".long_press"}, k, bus.long_press, lp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    bit pat [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        // Reset with button held
        bus.btn_raw = 1'b1;
        bus.tick    = 1'b0;
        rst_n       = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all("rst", i, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 14; k++) begin
            chk_all("s1_press", k, k >= 6, k == 6, k >= 6, 1'b0);
            step();
        end
        // Release, then clear the pending request with a tick
        for (int k = 0; k < 11; k++) begin
            bus.btn_raw = 1'b0;
            bus.tick    = (k == 8);
            chk_all("s1_release", k, k < 6, 1'b0, k <= 8, 1'b0);
            step();
        end
        bus.tick = 1'b0;

        // Bounce, then tick handshake (press at 10, ticks at 15 and 19)
        for (int k = 0; k < 30; k++) begin
            bus.btn_raw = (k < 5) ? pat[k] : (k < 20);
            bus.tick    = (k == 15) || (k == 19);
            chk_all("s2_bounce_tick", k, (k >= 10) && (k < 26), k == 10,
                    (k >= 10) && (k <= 15), 1'b0);
            step();
        end
        bus.tick = 1'b0;

        // Set-wins collision: second press sets on the edge ending cycle 27
        for (int k = 0; k < 46; k++) begin
            bus.btn_raw = (k < 12) || ((k >= 22) && (k < 34));
            bus.tick    = (k == 27) || (k == 30);
            chk_all("s4_collision", k, ((k >= 6) && (k < 18)) || ((k >= 28) && (k < 40)),
                    (k == 6) || (k == 28), (k >= 6) && (k <= 30), 1'b0);
            step();
        end
        bus.tick = 1'b0;

        // Long press: hold 40 cycles
        for (int k = 0; k < 56; k++) begin
            bus.btn_raw = (k < 40);
            bus.tick    = (k == 50);
            chk_all("s5_long", k, (k >= 6) && (k < 46), k == 6,
                    (k >= 6) && (k <= 50), k == 26);
            step();
        end
        bus.tick = 1'b0;

        // Release glitch of 2 raw cycles while held
        for (int k = 0; k < 51; k++) begin
            bus.btn_raw = ((k < 10) || (k >= 12)) && (k < 35);
            bus.tick    = (k == 45);
            chk_all("s6_glitch", k, (k >= 6) && (k < 41), k == 6,
                    (k >= 6) && (k <= 45), k == 26);
            step();
        end
        bus.tick = 1'b0;

        // Reset mid-hold with a pending request; button still held afterwards
        for (int k = 0; k < 36; k++) begin
            bus.btn_raw = (k < 26);
            bus.tick    = (k == 33);
            rst_n       = !((k == 10) || (k == 11));
            chk_all("s7_midreset", k, ((k >= 6) && (k <= 10)) || ((k >= 18) && (k < 32)),
                    (k == 6) || (k == 18),
                    ((k >= 6) && (k <= 10)) || ((k >= 18) && (k <= 33)), 1'b0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
